// File: rtl/l2_conv3x3_mac.sv
// 3x3 signed Q8.8 convolution MAC: streamed 9-word weight load, 4-stage product/adder-tree pipeline.
// Optional macro L2_CONV_RELU_EN clamps negative results to zero in the output stage.
module l2_conv3x3_mac #(
    parameter int DATA_W    = 16,
    parameter int IMG_HDISP = 64,
    parameter int IMG_VDISP = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  matrix_vsync,
    input  logic                  matrix_href,
    input  logic [6:0]            matrix_h_cnt,
    input  logic [6:0]            matrix_v_cnt,
    input  logic [9*DATA_W-1:0]   data_combination,
    input  logic                  w_valid,
    input  logic [DATA_W-1:0]     w_data,
    output logic                  w_ready,
    input  logic [DATA_W-1:0]     bias,
    output logic                  conv_valid,
    output logic [DATA_W-1:0]     conv_data,
    output logic                  conv_vsync
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 4;
    localparam logic [6:0] H_MAX = 7'(IMG_HDISP - 2);
    localparam logic [6:0] V_MAX = 7'(IMG_VDISP - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_ready_raw;
    logic                      w_accept;
    logic                      w_win_ok;
    logic [3:0]                r_widx;
    logic signed [DATA_W-1:0]  r_k [9];

    logic signed [DATA_W-1:0]  w_pix  [9];
    logic signed [PROD_W-1:0]  w_prod [9];
    logic signed [PROD_W-1:0]  r_prod [9];
    logic signed [ACC_W-1:0]   r_s    [5];
    logic signed [ACC_W-1:0]   r_t    [2];
    logic signed [DATA_W-1:0]  r_b1, r_b2, r_b3;
    logic                      r_v1, r_v2, r_v3;
    logic [3:0]                r_vs;
    logic                      r_conv_valid;
    logic [DATA_W-1:0]         r_conv_data;

    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic [DATA_W-1:0]         w_sat;
    logic [DATA_W-1:0]         w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready_raw = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_raw = 1'b1;
                if (w_valid) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ready_raw = 1'b1;
                if (w_valid && (r_widx == 4'd8)) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_ready_raw = !matrix_vsync;
                if (w_valid && !matrix_vsync) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gated with rst_n so the handshake reads 0 for the whole reset assertion.
    assign w_ready  = w_ready_raw & rst_n;
    assign w_accept = w_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_widx <= '0;
            for (int unsigned i = 0; i < 9; i++) r_k[i] <= '0;
        end else if (w_accept) begin
            r_k[r_widx] <= w_data;
            r_widx      <= (r_widx == 4'd8) ? 4'd0 : r_widx + 4'd1;
        end
    end

    // A window coinciding with a weight acceptance is dropped: new weights are on their way.
    assign w_win_ok = (r_state == S_RUN) && matrix_href && !w_accept &&
                      (matrix_h_cnt >= 7'd1) && (matrix_h_cnt <= H_MAX) &&
                      (matrix_v_cnt >= 7'd1) && (matrix_v_cnt <= V_MAX);

    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            w_pix[i]  = data_combination[(8 - i) * DATA_W +: DATA_W];
            w_prod[i] = PROD_W'(w_pix[i]) * PROD_W'(r_k[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 9; i++) r_prod[i] <= '0;
            for (int unsigned j = 0; j < 5; j++) r_s[j] <= '0;
            r_t[0]       <= '0;
            r_t[1]       <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_b3         <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            r_conv_valid <= 1'b0;
            r_conv_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < 9; i++) r_prod[i] <= w_prod[i];
            r_b1 <= bias;
            r_v1 <= w_win_ok;

            for (int unsigned j = 0; j < 4; j++) begin
                r_s[j] <= ACC_W'(r_prod[2*j]) + ACC_W'(r_prod[2*j+1]);
            end
            r_s[4] <= ACC_W'(r_prod[8]);
            r_b2   <= r_b1;
            r_v2   <= r_v1;

            r_t[0] <= r_s[0] + r_s[1];
            r_t[1] <= r_s[2] + r_s[3] + r_s[4];
            r_b3   <= r_b2;
            r_v3   <= r_v2;

            r_conv_valid <= r_v3;
            if (r_v3) r_conv_data <= w_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs <= '0;
        end else begin
            r_vs <= {r_vs[2:0], matrix_vsync};
        end
    end

    // Bias is Q8.8 against Q16.16 products, hence the <<< 8 before the common >>> 8.
    always_comb begin
        w_sum   = r_t[0] + r_t[1] + (ACC_W'(r_b3) <<< 8);
        w_shift = w_sum >>> 8;
        if (!w_shift[ACC_W-1] && (|w_shift[ACC_W-2:DATA_W-1])) begin
            w_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shift[ACC_W-1] && !(&w_shift[ACC_W-2:DATA_W-1])) begin
            w_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_sat = w_shift[DATA_W-1:0];
        end
`ifdef L2_CONV_RELU_EN
        w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
        w_res = w_sat;
`endif
    end

    assign conv_valid = r_conv_valid;
    assign conv_data  = r_conv_data;
    assign conv_vsync = r_vs[3];

endmodule

// File: doc/l2_conv3x3_mac.md
L2_CONV3X3_MAC -- requirements
Module: l2_conv3x3_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed Q8.8 sample and weight width.
REQ-002 SHALL have parameter IMG_HDISP, default 64, meaning window columns per line.
REQ-003 SHALL have parameter IMG_VDISP, default 64, meaning lines per frame.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port matrix_vsync  input  1  frame-active flag from the window generator.
REQ-007 SHALL have port matrix_href  input  1  window-valid strobe.
REQ-008 SHALL have port matrix_h_cnt  input  7  column index of the window centre.
REQ-009 SHALL have port matrix_v_cnt  input  7  line index of the window centre.
REQ-010 SHALL have port data_combination  input  9*DATA_W  window, p11 in the MSBs through p33 in the LSBs.
REQ-011 SHALL have port w_valid  input  1  weight word offered.
REQ-012 SHALL have port w_data  input  DATA_W  weight word, loaded in order k11 first, k33 last.
REQ-013 SHALL have port w_ready  output  1  block accepts a weight word.
REQ-014 SHALL have port bias  input  DATA_W  Q8.8 bias, sampled with the window.
REQ-015 SHALL have port conv_valid  output  1  result strobe.
REQ-016 SHALL have port conv_data  output  DATA_W  Q8.8 result.
REQ-017 SHALL have port conv_vsync  output  1  matrix_vsync delayed to align with conv_data.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD (on first accepted weight word) -> RUN (after the 9th accepted word) -> LOAD (on any accepted weight word in RUN).
REQ-019 SHALL assert w_ready in IDLE and LOAD; in RUN only while matrix_vsync=0.
REQ-020 SHALL accept a weight word when w_valid and w_ready are high; word index counter 0..8, wraps to 0 when the 9th word is accepted.
REQ-021 SHALL process windows only in RUN; windows presented in IDLE/LOAD SHALL be dropped with no conv_valid.
REQ-022 SHALL treat a window as valid when matrix_href=1, matrix_h_cnt in 1..IMG_HDISP-2 and matrix_v_cnt in 1..IMG_VDISP-2 (border windows dropped).
REQ-023 SHALL have pipeline: stage 1 registers 9 signed 2*DATA_W products; stage 2 adds pairs (5 terms, 4 sums + p33); stage 3 reduces to 2 terms; stage 4 forms full sum plus bias<<8, shifts arithmetically right by 8, saturates and registers.
REQ-024 SHALL give latency exactly 4 cycles from a valid window sample to conv_valid; throughput one window per cycle, no backpressure.
REQ-025 SHALL use a 2*DATA_W+4 bit accumulator; no intermediate overflow.
REQ-026 SHALL saturate the shifted sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 SHALL delay conv_vsync by matrix_vsync through 4 registers, independent of FSM state.
REQ-028 SHALL keep conv_data holding its last value while conv_valid=0.
REQ-029 SHALL, when a weight word is accepted in RUN, flush the valid pipeline: windows already in flight complete with the old weights, new windows dropped until 9 words loaded.

Reset
REQ-030 SHALL on rst_n=0 force state IDLE, word index 0, all weights 0, all pipeline valid bits 0, conv_valid=0, conv_data=0, conv_vsync=0, w_ready=0 while asserted.
REQ-031 SHALL, on reset asserted mid-frame, discard in-flight results with no conv_valid pulse after release until reload completes.

Configuration
REQ-032 SHALL support macro L2_CONV_RELU_EN: when defined, negative saturated results are output as 0 (stage 4, no added latency); when undefined, signed result passed unchanged.

Verification
REQ-033 SHALL cover: load 9 weights of 0x0100, window all 0x0100, bias 0 -> conv_data=0x0900 after 4 cycles.
REQ-034 SHALL cover: all weights 0x7FFF, all samples 0x7FFF -> conv_data=0x7FFF; all samples 0x8000 -> 0x8000 (0x0000 with L2_CONV_RELU_EN).
REQ-035 SHALL cover: 64x64 frame with href continuous -> exactly 62*62=3844 conv_valid pulses; none for h_cnt or v_cnt in {0,63}.
REQ-036 SHALL cover: windows before 9th weight accepted -> no conv_valid; 5 weights then rst_n pulse -> IDLE, index 0, no output.
REQ-037 SHALL cover: back-to-back valid windows with distinct values -> conv_valid high for same run length, results in order, 4-cycle offset, conv_vsync aligned.
REQ-038 SHALL cover: weight word offered in RUN with matrix_vsync=1 -> w_ready=0, word not taken; after vsync falls -> accepted, state LOAD.
